// File: rtl/eeprom_read_sched_pkg.sv
// Shared types and constants for the EEPROM read scheduler.
package eeprom_pkg;

    // Bits per assembled EEPROM word.
    localparam int EE_WORD_BITS = 32;

    // One beat of the SPI_EEPROM bit stream, in the controller's field order.
    typedef struct packed {
        logic word;   // last bit of a 32-bit word
        logic b;      // last bit of a byte
        logic data;   // serial data bit
        logic valid;  // data is valid this cycle
    } EEPROM_Packet;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_CANCEL
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan from lowest to highest priority so the closest requester after ptr wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/eeprom_read_sched.sv
// Round-robin read scheduler in front of the SPI_EEPROM bit-stream controller.
// Each granted request issues one read, assembles serial bits into 32-bit
// words, returns exactly the requested count and then cancels the stream.
module eeprom_read_sched
    import eeprom_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               IN_req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   IN_reqAddr,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]    IN_reqLen,
    output logic [NUM_REQ-1:0]               OUT_reqAck,
    output logic [EE_WORD_BITS-1:0]          OUT_word,
    output logic                             OUT_wordValid,
    output logic [ID_W-1:0]                  OUT_wordId,
    output logic                             OUT_done,
    output logic                             OUT_busy,
    output logic [ADDR_W-1:0]                OUT_eeAddr,
    output logic                             OUT_eeRead,
    output logic                             OUT_eeCancel,
    input  logic                             IN_eeData,
    input  logic                             IN_eeValid,
    input  logic                             IN_eeByte,
    input  logic                             IN_eeWord
);

    sched_state_t             state;
    logic [ID_W-1:0]          ptr;
    logic [ID_W-1:0]          id_q;
    logic [LEN_W-1:0]         cnt;
    logic [EE_WORD_BITS-1:0]  sr;
    logic [EE_WORD_BITS-1:0]  sr_next;
    logic [LEN_W-1:0]         cnt_dec;
    logic [NUM_REQ-1:0]       grant;
    logic [ID_W-1:0]          g_idx;
    EEPROM_Packet             pkt;

    // Byte strobe travels with the packet but the scheduler only counts words.
    logic unused_byte;

    assign pkt         = '{word: IN_eeWord, b: IN_eeByte, data: IN_eeData, valid: IN_eeValid};
    assign unused_byte = pkt.b;
    assign sr_next     = {sr[EE_WORD_BITS-2:0], pkt.data};
    assign cnt_dec     = (cnt != '0) ? cnt - LEN_W'(1) : '0;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (IN_req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (g_idx)
    );

    // Ack is combinational so a request is accepted in the cycle it is seen in IDLE;
    // gating with rst keeps it quiet while the block is held in reset.
    assign OUT_reqAck = (state == S_IDLE && rst) ? grant : '0;
    assign OUT_busy   = (state != S_IDLE);
    assign OUT_wordId = id_q;

    // Scheduler FSM with registered stream-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            ptr           <= ID_W'(NUM_REQ - 1);
            id_q          <= '0;
            cnt           <= '0;
            sr            <= '0;
            OUT_word      <= '0;
            OUT_wordValid <= 1'b0;
            OUT_done      <= 1'b0;
            OUT_eeAddr    <= '0;
            OUT_eeRead    <= 1'b0;
            OUT_eeCancel  <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register sees pre-edge values.
            OUT_wordValid <= 1'b0;
            OUT_done      <= 1'b0;
            OUT_eeRead    <= 1'b0;
            OUT_eeCancel  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|IN_req) begin
                        ptr  <= g_idx;
                        id_q <= g_idx;
                        cnt  <= IN_reqLen[g_idx];
                        if (IN_reqLen[g_idx] != '0) begin
                            OUT_eeAddr <= IN_reqAddr[g_idx];
                            OUT_eeRead <= 1'b1;
                            state      <= S_START;
                        end else begin
                            // Nothing to read: finish without touching the EEPROM.
                            state <= S_CANCEL;
                        end
                    end
                end
                S_START: begin
                    sr    <= '0;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (pkt.valid) begin
                        sr <= sr_next;
                        if (pkt.word) begin
                            OUT_word      <= sr_next;
                            OUT_wordValid <= 1'b1;
                            cnt           <= cnt_dec;
                            if (cnt_dec == '0) begin
                                OUT_eeCancel <= 1'b1;
                                state        <= S_CANCEL;
                            end
                        end
                    end
                end
                S_CANCEL: begin
                    // Stray bits from the EEPROM are ignored here.
                    OUT_done   <= 1'b1;
                    OUT_eeAddr <= '0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_read_sched.sv
// Self-checking bench for eeprom_read_sched: word scoreboard plus per-scenario checks.
module tb_eeprom_read_sched;

    localparam int NR = 2;
    localparam int AW = 24;
    localparam int LW = 8;
    localparam int IW = 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NR-1:0]           IN_req = '0;
    logic [NR-1:0][AW-1:0]   IN_reqAddr = '0;
    logic [NR-1:0][LW-1:0]   IN_reqLen = '0;
    logic [NR-1:0]           OUT_reqAck;
    logic [31:0]             OUT_word;
    logic                    OUT_wordValid;
    logic [IW-1:0]           OUT_wordId;
    logic                    OUT_done;
    logic                    OUT_busy;
    logic [AW-1:0]           OUT_eeAddr;
    logic                    OUT_eeRead;
    logic                    OUT_eeCancel;
    logic                    IN_eeData = 1'b0;
    logic                    IN_eeValid = 1'b0;
    logic                    IN_eeByte = 1'b0;
    logic                    IN_eeWord = 1'b0;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   word;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    eeprom_read_sched #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .IN_req        (IN_req),
        .IN_reqAddr    (IN_reqAddr),
        .IN_reqLen     (IN_reqLen),
        .OUT_reqAck    (OUT_reqAck),
        .OUT_word      (OUT_word),
        .OUT_wordValid (OUT_wordValid),
        .OUT_wordId    (OUT_wordId),
        .OUT_done      (OUT_done),
        .OUT_busy      (OUT_busy),
        .OUT_eeAddr    (OUT_eeAddr),
        .OUT_eeRead    (OUT_eeRead),
        .OUT_eeCancel  (OUT_eeCancel),
        .IN_eeData     (IN_eeData),
        .IN_eeValid    (IN_eeValid),
        .IN_eeByte     (IN_eeByte),
        .IN_eeWord     (IN_eeWord)
    );

    // Scoreboard: every word the DUT returns must match the oldest expectation.
    always @(negedge clk) begin
        if (OUT_wordValid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word: got id %0d word %h cancel %b, none expected",
                         OUT_wordId, OUT_word, OUT_eeCancel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({OUT_wordId, OUT_word, OUT_eeCancel} !== {e.id, e.word, e.last}) begin
                    n_bad++;
                    $display("FAIL word: got id %0d word %h cancel %b, want id %0d word %h cancel %b",
                             OUT_wordId, OUT_word, OUT_eeCancel, e.id, e.word, e.last);
                end
            end
        end else if (OUT_eeCancel) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cancel_alone: got cancel 1 without a word, want 0");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_ee();
        IN_eeValid = 1'b0;
        IN_eeData  = 1'b0;
        IN_eeWord  = 1'b0;
        IN_eeByte  = 1'b0;
    endtask

    task automatic push_word(input logic [IW-1:0] id, input logic [31:0] w, input logic last);
        exp_t e;
        e.id   = id;
        e.word = w;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Drive bits hi..lo of w MSB first, one per cycle; word strobe on bit 0.
    task automatic send_bits(input logic [31:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            IN_eeValid = 1'b1;
            IN_eeData  = w[i];
            IN_eeWord  = (i == 0);
            IN_eeByte  = (i % 8 == 0);
            tick();
        end
        idle_ee();
    endtask

    // Raise a request in IDLE, expect the same-cycle ack, then the one-cycle read.
    task automatic issue(input int r, input logic [AW-1:0] a, input logic [LW-1:0] len, input bit hold);
        IN_reqAddr[r] = a;
        IN_reqLen[r]  = len;
        IN_req[r]     = 1'b1;
        #1;
        n_cmp++;
        if (OUT_reqAck !== (2'b01 << r)) begin
            n_bad++;
            $display("FAIL ack_%0d: got %b want %b", r, OUT_reqAck, 2'b01 << r);
        end
        tick();
        n_cmp++;
        if ({OUT_reqAck, OUT_eeRead, OUT_eeAddr, OUT_busy} !== {2'b00, 1'b1, a, 1'b1}) begin
            n_bad++;
            $display("FAIL start_%0d: got ack %b read %b addr %h busy %b, want ack 00 read 1 addr %h busy 1",
                     r, OUT_reqAck, OUT_eeRead, OUT_eeAddr, OUT_busy, a);
        end
        if (!hold) IN_req[r] = 1'b0;
        tick();
        n_cmp++;
        if ({OUT_eeRead, OUT_eeAddr} !== {1'b0, a}) begin
            n_bad++;
            $display("FAIL read_pulse_%0d: got read %b addr %h, want read 0 addr %h",
                     r, OUT_eeRead, OUT_eeAddr, a);
        end
    endtask

    // Wait up to budget cycles for OUT_done, then check owner and return to IDLE.
    task automatic wait_done(input logic [IW-1:0] id, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (OUT_done) break;
        end
        n_cmp++;
        if (OUT_done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timeout: got done %b after %0d cycles, want 1", OUT_done, budget);
        end else if ({OUT_wordId, OUT_wordValid, OUT_busy, OUT_eeAddr} !== {id, 1'b0, 1'b0, {AW{1'b0}}}) begin
            n_bad++;
            $display("FAIL done: got id %0d valid %b busy %b addr %h, want id %0d valid 0 busy 0 addr 0",
                     OUT_wordId, OUT_wordValid, OUT_busy, OUT_eeAddr, id);
        end
    endtask

    task automatic test_reset();
        IN_reqAddr[0] = 24'h00A000;
        IN_reqAddr[1] = 24'h00B000;
        IN_reqLen[0]  = 8'd1;
        IN_reqLen[1]  = 8'd1;
        IN_req        = 2'b11;
        rst           = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({OUT_reqAck, OUT_word, OUT_wordValid, OUT_wordId, OUT_done, OUT_busy,
             OUT_eeAddr, OUT_eeRead, OUT_eeCancel} !== '0) begin
            n_bad++;
            $display("FAIL reset: got ack %b word %h valid %b id %0d done %b busy %b addr %h read %b cancel %b, want all 0",
                     OUT_reqAck, OUT_word, OUT_wordValid, OUT_wordId, OUT_done, OUT_busy,
                     OUT_eeAddr, OUT_eeRead, OUT_eeCancel);
        end
    endtask

    // Both requesters pending at reset release: 0 first, then 1.
    task automatic test_contention();
        rst = 1'b1;
        issue(0, 24'h00A000, 8'd1, 1'b0);
        push_word(1'b0, 32'hA5A5_0001, 1'b1);
        send_bits(32'hA5A5_0001, 31, 0);
        wait_done(1'b0, 1);
        issue(1, 24'h00B000, 8'd1, 1'b0);
        push_word(1'b1, 32'h5A5A_0002, 1'b1);
        send_bits(32'h5A5A_0002, 31, 0);
        wait_done(1'b1, 1);
        tick();
    endtask

    task automatic test_single();
        issue(0, 24'h000100, 8'd2, 1'b0);
        push_word(1'b0, 32'hDEADBEEF, 1'b0);
        push_word(1'b0, 32'h01234567, 1'b1);
        send_bits(32'hDEADBEEF, 31, 0);
        send_bits(32'h01234567, 31, 0);
        n_cmp++;
        if ({OUT_wordValid, OUT_eeCancel, OUT_busy} !== 3'b111) begin
            n_bad++;
            $display("FAIL last_word: got valid %b cancel %b busy %b, want 1 1 1",
                     OUT_wordValid, OUT_eeCancel, OUT_busy);
        end
        wait_done(1'b0, 1);
        tick();
        n_cmp++;
        if ({OUT_done, OUT_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL done_pulse: got done %b busy %b, want 0 0", OUT_done, OUT_busy);
        end
    endtask

    // req0 held throughout; req1 raised mid-stream must win the next grant.
    task automatic test_fairness();
        issue(0, 24'h000200, 8'd1, 1'b1);
        push_word(1'b0, 32'hCAFE_F00D, 1'b1);
        send_bits(32'hCAFE_F00D, 31, 16);
        IN_reqAddr[1] = 24'h000300;
        IN_reqLen[1]  = 8'd1;
        IN_req[1]     = 1'b1;
        send_bits(32'hCAFE_F00D, 15, 0);
        wait_done(1'b0, 1);
        issue(1, 24'h000300, 8'd1, 1'b0);
        push_word(1'b1, 32'h1357_9BDF, 1'b1);
        send_bits(32'h1357_9BDF, 31, 0);
        wait_done(1'b1, 1);
        issue(0, 24'h000200, 8'd1, 1'b0);
        push_word(1'b0, 32'h8000_0001, 1'b1);
        send_bits(32'h8000_0001, 31, 0);
        wait_done(1'b0, 1);
        tick();
    endtask

    task automatic test_zero_len();
        IN_reqAddr[1] = 24'h000400;
        IN_reqLen[1]  = 8'd0;
        IN_req[1]     = 1'b1;
        #1;
        n_cmp++;
        if (OUT_reqAck !== 2'b10) begin
            n_bad++;
            $display("FAIL zero_ack: got %b want 10", OUT_reqAck);
        end
        tick();
        n_cmp++;
        if ({OUT_eeRead, OUT_busy, OUT_done, OUT_wordValid} !== 4'b0100) begin
            n_bad++;
            $display("FAIL zero_cancel: got read %b busy %b done %b valid %b, want 0 1 0 0",
                     OUT_eeRead, OUT_busy, OUT_done, OUT_wordValid);
        end
        IN_req[1] = 1'b0;
        wait_done(1'b1, 1);
        tick();
    endtask

    // A valid bit (even with word strobe) during CANCEL must be dropped.
    task automatic test_stray();
        issue(0, 24'h000500, 8'd1, 1'b0);
        push_word(1'b0, 32'h0F0F_F0F0, 1'b1);
        send_bits(32'h0F0F_F0F0, 31, 0);
        IN_eeValid = 1'b1;
        IN_eeData  = 1'b1;
        IN_eeWord  = 1'b1;
        wait_done(1'b0, 1);
        idle_ee();
        issue(0, 24'h000600, 8'd1, 1'b0);
        push_word(1'b0, 32'h7654_3210, 1'b1);
        send_bits(32'h7654_3210, 31, 0);
        wait_done(1'b0, 1);
        tick();
    endtask

    task automatic test_reset_mid_stream();
        issue(0, 24'h000700, 8'd1, 1'b0);
        send_bits(32'hFFFF_FFFF, 31, 15);
        IN_req[1]     = 1'b1;
        IN_reqLen[1]  = 8'd1;
        IN_reqAddr[1] = 24'h000800;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({OUT_reqAck, OUT_word, OUT_wordValid, OUT_wordId, OUT_done, OUT_busy,
             OUT_eeAddr, OUT_eeRead, OUT_eeCancel} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got ack %b word %h valid %b id %0d done %b busy %b addr %h read %b cancel %b, want all 0",
                     OUT_reqAck, OUT_word, OUT_wordValid, OUT_wordId, OUT_done, OUT_busy,
                     OUT_eeAddr, OUT_eeRead, OUT_eeCancel);
        end
        IN_req[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        issue(0, 24'h000900, 8'd1, 1'b0);
        push_word(1'b0, 32'h2468_ACE0, 1'b1);
        send_bits(32'h2468_ACE0, 31, 0);
        wait_done(1'b0, 1);
        tick();
    endtask

    initial begin
        idle_ee();
        test_reset();
        test_contention();
        test_single();
        test_fairness();
        test_zero_len();
        test_stray();
        test_reset_mid_stream();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_words: got %0d words never returned, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
